// File: rtl/ex_mdu_seq_pkg.sv
// Shared op codes, divider state encoding and a small arithmetic helper
// for the EX-stage multiply-accumulate / divide unit.
package ex_mdu_seq_pkg;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StByZero = 2'b01,
    StOn     = 2'b10,
    StEnd    = 2'b11
  } div_state_e;

  // Two's-complement negate when en is set.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_mdu_seq_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, result registered
// and held in StEnd while the pipeline keeps EX stalled.
module ex_mdu_seq_div_iter
  import ex_mdu_seq_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_signed_div,
  input  logic        i_annul,
  input  logic        i_stall,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_ready,
  output logic [63:0] o_result
);

  div_state_e  r_state;
  // [64:32] shifted partial remainder window, [31:0] dividend bits / quotient bits
  logic [64:0] r_pq;
  logic [31:0] r_divisor;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_ready;
  logic [63:0] r_result;

  logic [32:0] w_trial;
  logic [64:0] w_pq_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_trial   = r_pq[64:32] - {1'b0, r_divisor};
  assign w_pq_next = w_trial[32] ? {r_pq[63:0], 1'b0} : {w_trial[31:0], r_pq[31:0], 1'b1};
  assign w_quo     = cond_neg(w_pq_next[31:0], r_neg_q);
  assign w_rem     = cond_neg(w_pq_next[64:33], r_neg_r);

  always_ff @(posedge clk) begin
    if (rst || i_annul) begin
      r_state   <= StIdle;
      r_pq      <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_pq      <= {32'd0, cond_neg(i_op1, i_signed_div & i_op1[31]), 1'b0};
            r_divisor <= cond_neg(i_op2, i_signed_div & i_op2[31]);
            r_neg_q   <= i_signed_div & (i_op1[31] ^ i_op2[31]);
            r_neg_r   <= i_signed_div & i_op1[31];
            r_cnt     <= '0;
            r_state   <= (i_op2 == 32'd0) ? StByZero : StOn;
          end
        end
        StByZero: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= StEnd;
        end
        StOn: begin
          r_pq  <= w_pq_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(DIV_STEPS - 1)) begin
            r_result <= {w_rem, w_quo};
            r_ready  <= 1'b1;
            r_state  <= StEnd;
          end
        end
        StEnd: begin
          if (!i_stall) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= StIdle;
          end
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_result = r_result;

endmodule

// File: rtl/ex_mdu_seq.sv
// EX-stage multiply-accumulate / divide unit. MADD/MSUB state lives in EX/MEM
// (hilo_temp/cnt round trip); divides run in the iterative sub-module.
module ex_mdu_seq
  import ex_mdu_seq_pkg::*;
#(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall_ex,
  input  logic [7:0]  aluop,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o,
  output logic        stallreq,
  output logic        whilo,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic        w_is_mac;
  logic        w_is_sub;
  logic        w_is_uns;
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_div_ready;
  logic [63:0] w_prod;
  logic [63:0] w_acc;
  logic [63:0] w_div_result;

  always_comb begin
    w_is_mac = 1'b0;
    w_is_sub = 1'b0;
    w_is_uns = 1'b0;
    case (aluop)
      EXE_MADD_OP:  w_is_mac = 1'b1;
      EXE_MADDU_OP: begin w_is_mac = 1'b1; w_is_uns = 1'b1; end
      EXE_MSUB_OP:  begin w_is_mac = 1'b1; w_is_sub = 1'b1; end
      EXE_MSUBU_OP: begin w_is_mac = 1'b1; w_is_sub = 1'b1; w_is_uns = 1'b1; end
      default: ;
    endcase
  end

  assign w_is_div     = (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  assign w_div_signed = (aluop == EXE_DIV_OP);

  // Low 64 bits of a 64x64 product of the extended operands is the exact 32x32 product.
  assign w_prod = w_is_uns ? ({32'd0, reg1} * {32'd0, reg2})
                           : ({{32{reg1[31]}}, reg1} * {{32{reg2[31]}}, reg2});
  assign w_acc  = w_is_sub ? ({hi_i, lo_i} - hilo_temp_i) : ({hi_i, lo_i} + hilo_temp_i);

  ex_mdu_seq_div_iter #(
    .DIV_STEPS(DIV_STEPS)
  ) u_div_iter (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_is_div),
    .i_signed_div (w_div_signed),
    .i_annul      (flush | ~w_is_div),
    .i_stall      (stall_ex),
    .i_op1        (reg1),
    .i_op2        (reg2),
    .o_ready      (w_div_ready),
    .o_result     (w_div_result)
  );

  always_comb begin
    hilo_temp_o = '0;
    cnt_o       = 2'd0;
    stallreq    = 1'b0;
    whilo       = 1'b0;
    hi_o        = '0;
    lo_o        = '0;
    if (w_is_mac) begin
      case (cnt_i)
        2'd0: begin
          hilo_temp_o = w_prod;
          cnt_o       = 2'd1;
          stallreq    = 1'b1;
        end
        2'd1: begin
          {hi_o, lo_o} = w_acc;
          whilo        = 1'b1;
          cnt_o        = 2'd2;
        end
        default: ;
      endcase
    end else if (w_is_div) begin
      stallreq     = ~w_div_ready;
      whilo        = w_div_ready;
      {hi_o, lo_o} = w_div_result;
    end
  end

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Directed self-checking bench for ex_mdu_seq: MADD/MSUB round trips and
// divider latency, result, flush and hold behaviour.
module tb_ex_mdu_seq;
  import ex_mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, stall_ex;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2, hi_i, lo_i;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  logic        stallreq, whilo;
  logic [31:0] hi_o, lo_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mdu_seq #(
    .DIV_STEPS(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .stall_ex    (stall_ex),
    .aluop       (aluop),
    .reg1        (reg1),
    .reg2        (reg2),
    .hi_i        (hi_i),
    .lo_i        (lo_i),
    .hilo_temp_i (hilo_temp_i),
    .cnt_i       (cnt_i),
    .hilo_temp_o (hilo_temp_o),
    .cnt_o       (cnt_o),
    .stallreq    (stallreq),
    .whilo       (whilo),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all(input string tag, input logic [63:0] e_temp, input logic [1:0] e_cnt,
                           input logic e_stall, input logic e_whilo, input logic [63:0] e_hilo);
    check({tag, " hilo_temp_o"}, hilo_temp_o, e_temp);
    check({tag, " cnt_o"}, {62'd0, cnt_o}, {62'd0, e_cnt});
    check({tag, " stallreq"}, {63'd0, stallreq}, {63'd0, e_stall});
    check({tag, " whilo"}, {63'd0, whilo}, {63'd0, e_whilo});
    check({tag, " hi/lo"}, {hi_o, lo_o}, e_hilo);
  endtask

  // Starts (or continues) a divide, counts stallreq cycles, checks the END outputs.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall, input logic [63:0] exp_res,
                         input bit scramble);
    int n = 0;
    aluop = op; reg1 = a; reg2 = b; stall_ex = 1'b1;
    #1;
    while (stallreq === 1'b1 && n < 100) begin
      n++;
      tick();
      if (scramble && n == 5) begin
        reg1 = 32'h1234_5678;
        reg2 = 32'h0;
      end
      #1;
    end
    check({tag, " stall cycles"}, 64'(n), 64'(exp_stall));
    check_all({tag, " end"}, 64'd0, 2'd0, 1'b0, 1'b1, exp_res);
  endtask

  task automatic end_div(input string tag);
    stall_ex = 1'b0;
    tick();
    aluop = EXE_NOP_OP;
    #1;
    check_all({tag, " after"}, 64'd0, 2'd0, 1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_ex = 1'b0; aluop = EXE_NOP_OP;
    reg1 = '0; reg2 = '0; hi_i = '0; lo_i = '0; hilo_temp_i = '0; cnt_i = '0;
    tick();
    tick();
    #1;
    check_all("reset", 64'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    rst = 1'b0;

    // Non-MDU op with live operands
    aluop = 8'b0010_0000; reg1 = 32'hDEAD_BEEF; reg2 = 32'h5; cnt_i = 2'd1;
    hilo_temp_i = 64'h55; #1;
    check_all("non-mdu", 64'd0, 2'd0, 1'b0, 1'b0, 64'd0);

    // MADD 3*4 + 0x1_00000005
    tick();
    aluop = EXE_MADD_OP; reg1 = 32'd3; reg2 = 32'd4; hi_i = 32'd1; lo_i = 32'd5;
    cnt_i = 2'd0; hilo_temp_i = 64'd0; #1;
    check_all("madd c0", 64'hC, 2'd1, 1'b1, 1'b0, 64'd0);
    tick();
    cnt_i = 2'd1; hilo_temp_i = 64'hC; #1;
    check_all("madd c1", 64'd0, 2'd2, 1'b0, 1'b1, 64'h0000_0001_0000_0011);
    tick();
    cnt_i = 2'd2; #1;
    check_all("madd c2", 64'd0, 2'd0, 1'b0, 1'b0, 64'd0);

    // Signedness of the product
    tick();
    aluop = EXE_MADDU_OP; reg1 = 32'hFFFF_FFFF; reg2 = 32'd2; cnt_i = 2'd0; #1;
    check("maddu prod", hilo_temp_o, 64'h0000_0001_FFFF_FFFE);
    aluop = EXE_MADD_OP; #1;
    check("madd neg prod", hilo_temp_o, 64'hFFFF_FFFF_FFFF_FFFE);

    // MSUB / MSUBU of 0xFFFFFFFE * 3 from zero
    tick();
    aluop = EXE_MSUB_OP; reg1 = 32'hFFFF_FFFE; reg2 = 32'd3; hi_i = '0; lo_i = '0;
    cnt_i = 2'd0; hilo_temp_i = '0; #1;
    check_all("msub c0", 64'hFFFF_FFFF_FFFF_FFFA, 2'd1, 1'b1, 1'b0, 64'd0);
    tick();
    cnt_i = 2'd1; hilo_temp_i = 64'hFFFF_FFFF_FFFF_FFFA; #1;
    check_all("msub c1", 64'd0, 2'd2, 1'b0, 1'b1, 64'h6);
    tick();
    aluop = EXE_MSUBU_OP; cnt_i = 2'd0; hilo_temp_i = '0; #1;
    check("msubu c0 prod", hilo_temp_o, 64'h0000_0002_FFFF_FFFA);
    tick();
    cnt_i = 2'd1; hilo_temp_i = 64'h0000_0002_FFFF_FFFA; #1;
    check_all("msubu c1", 64'd0, 2'd2, 1'b0, 1'b1, 64'hFFFF_FFFD_0000_0006);
    tick();
    aluop = EXE_NOP_OP; cnt_i = 2'd0; hilo_temp_i = '0;
    tick();

    // Divides: {hi=remainder, lo=quotient}
    run_div("div -7/2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    end_div("div -7/2");
    run_div("divu", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, 33, 64'h0000_000F_0FFF_FFFF, 1'b0);
    end_div("divu");
    run_div("divu big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0001, 33,
            64'h7FFF_FFFE_0000_0001, 1'b0);
    end_div("divu big");
    run_div("div ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            64'h0000_0000_8000_0000, 1'b0);
    end_div("div ovf");
    run_div("div by0", EXE_DIV_OP, 32'd1234, 32'd0, 2, 64'd0, 1'b0);
    end_div("div by0");

    // Flush at step 10 then reissue
    aluop = EXE_DIV_OP; reg1 = 32'hFFFF_FFF9; reg2 = 32'd2; stall_ex = 1'b1;
    repeat (11) tick();
    flush = 1'b1; #1;
    tick();
    flush = 1'b0; #1;
    check("flush whilo", {63'd0, whilo}, 64'd0);
    check("flush restart stallreq", {63'd0, stallreq}, 64'd1);
    run_div("div reissue", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    end_div("div reissue");

    // Hold in END for 3 stalled cycles: 100 / -7 = -14 rem 2
    run_div("div hold", EXE_DIV_OP, 32'd100, 32'hFFFF_FFF9, 33, 64'h0000_0002_FFFF_FFF2, 1'b0);
    for (int i = 1; i < 3; i++) begin
      tick();
      #1;
      check_all("div hold cyc", 64'd0, 2'd0, 1'b0, 1'b1, 64'h0000_0002_FFFF_FFF2);
    end
    stall_ex = 1'b0; #1;
    check("div hold release whilo", {63'd0, whilo}, 64'd1);
    tick();
    #1;
    check("div hold idle whilo", {63'd0, whilo}, 64'd0);
    check("div hold idle restart", {63'd0, stallreq}, 64'd1);
    aluop = EXE_NOP_OP;
    tick();
    #1;
    check_all("final nop", 64'd0, 2'd0, 1'b0, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
